// File: rtl/pc_pkg.sv
// Shared types for the program-counter sequencer: FSM states, next-PC select
// encoding and the target alignment mask.
package pc_pkg;

  typedef enum logic [1:0] {
    BOOT = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } pc_state_e;

  typedef enum logic [2:0] {
    SEL_TRAP  = 3'd0,
    SEL_REDIR = 3'd1,
    SEL_PEND  = 3'd2,
    SEL_SEQ   = 3'd3,
    SEL_HOLD  = 3'd4
  } pc_sel_e;

  // Mask that clears the low log2(inc) bits; inc must be a power of two.
  function automatic logic [63:0] align_mask(input int unsigned inc);
    return ~(64'(inc) - 64'd1);
  endfunction

endpackage

// File: rtl/pc_ras.sv
// Circular return-address stack used by pc_seq when PC_RAS_EN is defined.
// Pushing when full overwrites the oldest entry; popping when empty is ignored.
module pc_ras #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] data,
  output logic [WIDTH-1:0] top,
  output logic             empty,
  output logic             full
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    tp;
  logic [PW-1:0]    wp_inc;
  logic [CW-1:0]    cnt;
  logic             do_pop;

  // wp is the next free slot; tp is the current top of stack.
  assign tp     = (wp == '0) ? LAST : wp - 1'b1;
  assign wp_inc = (wp == LAST) ? '0 : wp + 1'b1;
  assign do_pop = pop && !empty;
  assign top    = mem[tp];
  assign empty  = (cnt == '0);
  assign full   = (cnt == CW'(DEPTH));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wp  <= '0;
      cnt <= '0;
    end else if (do_pop && !push) begin
      wp  <= tp;
      cnt <= cnt - 1'b1;
    end else if (push && !do_pop) begin
      wp <= wp_inc;
      if (!full) cnt <= cnt + 1'b1;
    end
  end

  // Pop and push together replace the top entry in place.
  always_ff @(posedge clk) begin
    if (push) mem[do_pop ? tp : wp] <= data;
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: fetch address with valid/ready, stall, redirect,
// trap and stall-deferred redirects. Optional return-address stack: PC_RAS_EN.
module pc_seq
  import pc_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VEC = '0,
  parameter int               INC       = 4,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             redir_valid,
  input  logic [WIDTH-1:0] redir_addr,
  input  logic             trap_valid,
  input  logic [WIDTH-1:0] trap_vec,
  input  logic             fetch_ready,
`ifdef PC_RAS_EN
  input  logic             call_i,
  input  logic             ret_i,
  output logic             ras_empty,
  output logic             ras_full,
`endif
  output logic [WIDTH-1:0] pc,
  output logic             pc_valid,
  output logic [WIDTH-1:0] pc_next,
  output logic [WIDTH-1:0] pc_plus,
  output logic             misalign,
  output pc_state_e        state
);

  localparam logic [WIDTH-1:0] MASK = WIDTH'(align_mask(INC));

  // Handshake: a fetch of pc happens in a cycle where pc_valid && fetch_ready;
  // once pc_valid is raised, pc stays stable until that happens unless a
  // trap or redirect replaces the request.
  logic             adv;
  logic             mis_d;
  logic             pend_valid;
  logic [WIDTH-1:0] pend_addr;
  logic [WIDTH-1:0] raw;
  logic [WIDTH-1:0] target;
  logic             ras_hit;
  logic [WIDTH-1:0] ras_top;
  pc_sel_e          sel;

  assign pc_plus  = pc + WIDTH'(INC);
  assign adv      = (state == RUN) && fetch_ready && !stall;
  // Gated by stall so the request drops in the very cycle the multiplier stalls.
  assign pc_valid = (state == RUN) && !stall;

`ifdef PC_RAS_EN
  logic ras_pop;
  logic ras_push;

  assign ras_hit  = ret_i && !redir_valid && !trap_valid && !ras_empty;
  assign ras_pop  = ret_i && (!redir_valid || call_i) && !trap_valid;
  assign ras_push = call_i && redir_valid && !trap_valid;

  pc_ras #(
    .WIDTH(WIDTH),
    .DEPTH(RAS_DEPTH)
  ) u_ras (
    .clk  (clk),
    .rst  (rst),
    .push (ras_push),
    .pop  (ras_pop),
    .data (pc_plus),
    .top  (ras_top),
    .empty(ras_empty),
    .full (ras_full)
  );
`else
  logic unused_ras;

  assign ras_hit    = 1'b0;
  assign ras_top    = '0;
  assign unused_ras = ^RAS_DEPTH;
`endif

  always_comb begin
    sel    = SEL_HOLD;
    raw    = '0;
    target = pc;
    if (trap_valid) begin
      sel = SEL_TRAP;
      raw = trap_vec;
    end else if (redir_valid) begin
      sel = SEL_REDIR;
      raw = redir_addr;
    end else if (ras_hit) begin
      sel = SEL_REDIR;
      raw = ras_top;
    end else if (pend_valid) begin
      sel = SEL_PEND;
    end else if (adv) begin
      sel = SEL_SEQ;
    end
    case (sel)
      SEL_TRAP, SEL_REDIR: target = raw & MASK;
      SEL_PEND:            target = pend_addr;
      SEL_SEQ:             target = pc_plus;
      default:             target = pc;
    endcase
    pc_next = stall ? pc : target;
  end

  assign mis_d = ((sel == SEL_TRAP) || (sel == SEL_REDIR)) && (|(raw & ~MASK));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= BOOT;
      pc         <= RESET_VEC;
      misalign   <= 1'b0;
      pend_valid <= 1'b0;
      pend_addr  <= '0;
    end else begin
      pc       <= pc_next;
      misalign <= mis_d;
      state    <= stall ? HOLD : RUN;
      // Any unstalled cycle consumes or supersedes the deferred target.
      if (!stall) begin
        pend_valid <= 1'b0;
      end else if ((sel == SEL_TRAP) || (sel == SEL_REDIR)) begin
        pend_valid <= 1'b1;
        pend_addr  <= target;
      end
    end
  end

endmodule

// File: tb/tb_pc_seq.sv
// Self-checking bench for pc_seq: directed scenarios plus randomized traffic
// against a cycle-level reference model; fetches are checked through a queue.
module tb_pc_seq;

  localparam int         W     = 32;
  localparam logic [W-1:0] RV    = 32'h0000_0000;
  localparam logic [W-1:0] AMASK = 32'hFFFF_FFFC;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         stall = 1'b0;
  logic         redir_valid = 1'b0;
  logic [W-1:0] redir_addr = '0;
  logic         trap_valid = 1'b0;
  logic [W-1:0] trap_vec = '0;
  logic         fetch_ready = 1'b0;
  logic [W-1:0] pc;
  logic         pc_valid;
  logic [W-1:0] pc_next;
  logic [W-1:0] pc_plus;
  logic         misalign;
  pc_pkg::pc_state_e state;
`ifdef PC_RAS_EN
  logic         call_i = 1'b0;
  logic         ret_i = 1'b0;
  logic         ras_empty;
  logic         ras_full;
  logic [W-1:0] m_stack[$];
`endif

  int           n_checks = 0;
  int           n_fail = 0;
  logic [W-1:0] exp_q[$];

  // Reference model state
  logic [W-1:0] m_pc;
  logic [W-1:0] m_pend;
  logic         m_pend_v;
  logic         m_live;
  logic         m_mis;

  pc_seq dut (
    .clk        (clk),
    .rst        (rst),
    .stall      (stall),
    .redir_valid(redir_valid),
    .redir_addr (redir_addr),
    .trap_valid (trap_valid),
    .trap_vec   (trap_vec),
    .fetch_ready(fetch_ready),
`ifdef PC_RAS_EN
    .call_i     (call_i),
    .ret_i      (ret_i),
    .ras_empty  (ras_empty),
    .ras_full   (ras_full),
`endif
    .pc         (pc),
    .pc_valid   (pc_valid),
    .pc_next    (pc_next),
    .pc_plus    (pc_plus),
    .misalign   (misalign),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic void m_reset();
    m_pc     = RV;
    m_pend   = '0;
    m_pend_v = 1'b0;
    m_live   = 1'b0;
    m_mis    = 1'b0;
`ifdef PC_RAS_EN
    m_stack.delete();
`endif
  endfunction

  // Called just after a posedge; asserts reset mid-cycle and checks it takes effect at once.
  task automatic do_reset();
    #3 rst = 1'b0;
    #1;
    chk("rst_pc", pc, RV);
    chk("rst_valid", pc_valid, 1'b0);
    chk("rst_misalign", misalign, 1'b0);
    chk("rst_state", state, pc_pkg::BOOT);
    stall = 1'b0; redir_valid = 1'b0; trap_valid = 1'b0; fetch_ready = 1'b0;
    m_reset();
    repeat (2) @(posedge clk);
    #2 rst = 1'b1;
  endtask

  // One clock cycle: drive inputs, predict outputs, check, then advance the model.
  task automatic step(input logic s, input logic rv, input logic [W-1:0] ra,
                      input logic tv, input logic [W-1:0] ta, input logic rdy);
    logic [W-1:0] nxt;
    logic [W-1:0] tgt;
    logic         val;
    logic         mis;
    logic         tvalid;
    @(negedge clk);
    stall = s; redir_valid = rv; redir_addr = ra;
    trap_valid = tv; trap_vec = ta; fetch_ready = rdy;
    val = m_live && !s;
    if (val && rdy) exp_q.push_back(m_pc);
    tvalid = tv || rv;
    tgt    = m_pc;
    if (tv) tgt = ta & AMASK;
    else if (rv) tgt = ra & AMASK;
`ifdef PC_RAS_EN
    else if (ret_i && m_stack.size() > 0) begin
      tvalid = 1'b1;
      tgt    = m_stack[$];
    end
`endif
    mis = (tv && (ta[1:0] != 2'b00)) || (!tv && rv && (ra[1:0] != 2'b00));
    if (s) nxt = m_pc;
    else if (tvalid) nxt = tgt;
    else if (m_pend_v) nxt = m_pend;
    else if (val && rdy) nxt = m_pc + 32'd4;
    else nxt = m_pc;
    #1;
    chk("pc", pc, m_pc);
    chk("pc_valid", pc_valid, val);
    chk("pc_next", pc_next, nxt);
    chk("pc_plus", pc_plus, m_pc + 32'd4);
    chk("misalign", misalign, m_mis);
`ifdef PC_RAS_EN
    chk("ras_empty", ras_empty, m_stack.size() == 0);
    chk("ras_full", ras_full, m_stack.size() == 4);
`endif
    @(posedge clk);
`ifdef PC_RAS_EN
    if (ret_i && (!rv || call_i) && !tv && m_stack.size() > 0) void'(m_stack.pop_back());
    if (call_i && rv && !tv) begin
      m_stack.push_back(m_pc + 32'd4);
      if (m_stack.size() > 4) void'(m_stack.pop_front());
    end
`endif
    m_pc   = nxt;
    m_mis  = mis;
    m_live = !s;
    if (!s) m_pend_v = 1'b0;
    else if (tvalid) begin
      m_pend_v = 1'b1;
      m_pend   = tgt;
    end
  endtask

  task automatic expect_pc(input string name, input logic [W-1:0] v);
    #1 chk(name, pc, v);
  endtask

  // Monitor: every accepted fetch must match the next expected address.
  initial begin : monitor
    logic [W-1:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (rst && pc_valid && fetch_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL fetch: got %h expected no fetch", pc);
        end else begin
          e = exp_q.pop_front();
          if (pc !== e) begin
            n_fail++;
            $display("FAIL fetch: got %h expected %h", pc, e);
          end
        end
      end
    end
  end

  initial begin : stimulus
    logic [W-1:0] a;
    logic [W-1:0] b;
    m_reset();
    do_reset();

    // Boot then sequential fetch 0, 4
    step(0, 0, '0, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t1_seq", 32'h8);

    // Imem back-pressure at 0x8
    repeat (3) step(0, 0, '0, 0, '0, 0);
    expect_pc("t2_hold", 32'h8);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t2_release", 32'hC);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t3_start", 32'h10);

    // Redirect arrives during a stall and is applied when it drops
    step(1, 0, '0, 0, '0, 1);
    step(1, 1, 32'h2000_0000, 0, '0, 1);
    step(1, 0, '0, 0, '0, 1);
    step(1, 0, '0, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t3_redir", 32'h2000_0000);
    step(0, 0, '0, 0, '0, 1);

    // Trap beats redirect; misaligned redirect is truncated and flagged
    step(0, 1, 32'h1000_0002, 1, 32'h100, 1);
    expect_pc("t4_trap", 32'h100);
    step(0, 1, 32'h1000_0002, 0, '0, 0);
    expect_pc("t4_align", 32'h1000_0000);
    chk("t4_mis_pulse", misalign, 1'b1);
    step(0, 0, '0, 0, '0, 0);
    expect_pc("t4_mis_hold_pc", 32'h1000_0000);
    chk("t4_mis_clear", misalign, 1'b0);

    // Wrap-around, then reset while a redirect is pending
    step(0, 1, 32'hFFFF_FFFC, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t5_wrap", 32'h0);
    step(1, 0, '0, 0, '0, 1);
    step(1, 1, 32'h500, 0, '0, 1);
    do_reset();
    step(0, 0, '0, 0, '0, 1);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t5_no_pend", 32'h4);

`ifdef PC_RAS_EN
    // Five nested calls into a four-entry stack, then five returns
    step(0, 1, 32'h40, 0, '0, 1);
    call_i = 1'b1;
    for (int i = 0; i < 5; i++) step(0, 1, 32'h200 + 32'(i) * 32'h100, 0, '0, 1);
    call_i = 1'b0;
    ret_i  = 1'b1;
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t6_ret1", 32'h504);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t6_ret2", 32'h404);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t6_ret3", 32'h304);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t6_ret4", 32'h204);
    step(0, 0, '0, 0, '0, 1);
    expect_pc("t6_ret5_seq", 32'h208);
    chk("t6_empty", ras_empty, 1'b1);
    ret_i = 1'b0;
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      a = $urandom;
      b = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      if ($urandom_range(0, 3) != 0) b[1:0] = 2'b00;
      step($urandom_range(0, 9) < 2, $urandom_range(0, 9) < 1, a,
           $urandom_range(0, 19) == 0, b, $urandom_range(0, 9) < 7);
      if (i == 700) do_reset();
    end

    repeat (3) @(negedge clk);
    chk("fetch_queue_left", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
